// File: rtl/tdm_demux_rx_pkg.sv
// Shared definitions for the TDM link: receiver state encoding and default frame geometry.
// The default constants are also used by the transmitting mux side.
package tdm_demux_rx_pkg;

    typedef enum logic {
        StHunt = 1'b0,
        StRecv = 1'b1
    } rx_state_e;

    localparam int unsigned TdmNch = 8;
    localparam int unsigned TdmSw  = 3;

    // Slot index width for a given channel count
    function automatic int unsigned slot_width(input int unsigned nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NCH slot counter. load0 marks a sync beat as slot 0, so the next expected slot is 1.
// clr returns the counter to 0 when framing is lost. NCH need not be a power of two.
module tdm_slot_counter
    import tdm_demux_rx_pkg::*;
#(
    parameter int unsigned NCH = TdmNch,
    parameter int unsigned SW  = TdmSw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load0,
    input  logic          clr,
    output logic [SW-1:0] cnt,
    output logic          at_last
);

    logic [SW-1:0] cnt_q;

    // Slot index register: clear has priority, then sync load, then advance with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load0) begin
            cnt_q <= SW'(1);
        end else if (en) begin
            cnt_q <= at_last ? '0 : cnt_q + SW'(1);
        end
    end

    // Explicit compare against NCH-1; a natural binary wrap would be wrong for NCH=6 etc.
    assign at_last = (cnt_q == SW'(NCH - 1));
    assign cnt     = cnt_q;

endmodule

// File: rtl/tdm_demux_rx.sv
// Receive side of the TDM link: assembles one bit per slot into an NCH-bit word,
// publishes each complete frame with a one-cycle dout_valid and flags framing errors.
module tdm_demux_rx
    import tdm_demux_rx_pkg::*;
#(
    parameter int unsigned NCH = TdmNch,
    parameter int unsigned SW  = TdmSw
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           din,
    input  logic           din_valid,
    input  logic           sync,
    output logic [NCH-1:0] dout,
    output logic           dout_valid,
    output logic           sync_err,
    output logic [SW-1:0]  slot_idx
);

    rx_state_e      state_q;
    logic [NCH-1:0] asm_q;
    logic [NCH-1:0] frame_word;
    logic [SW-1:0]  cnt;
    logic           at_last;
    logic           ctr_en;
    logic           ctr_load0;
    logic           ctr_clr;

    tdm_slot_counter #(
        .NCH (NCH),
        .SW  (SW)
    ) u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (ctr_en),
        .load0   (ctr_load0),
        .clr     (ctr_clr),
        .cnt     (cnt),
        .at_last (at_last)
    );

    // Counter control: sync always restarts at slot 0; a non-sync beat at slot 0 loses framing.
    always_comb begin
        ctr_en    = 1'b0;
        ctr_load0 = 1'b0;
        ctr_clr   = 1'b0;
        if (din_valid) begin
            if (sync) begin
                ctr_load0 = 1'b1;
            end else if (state_q == StRecv) begin
                if (cnt == '0) begin
                    ctr_clr = 1'b1;
                end else begin
                    ctr_en = 1'b1;
                end
            end
        end
    end

    // Final slot bypasses the assembly register so dout loads on the same edge.
    always_comb begin
        frame_word        = asm_q;
        frame_word[NCH-1] = din;
    end

    // Framing FSM with registered assembly, output word and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StHunt;
            asm_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
            if (din_valid) begin
                if (sync) begin
                    // A sync anywhere but slot 0 of a running frame discards the partial word.
                    if (state_q == StRecv && cnt != '0) begin
                        sync_err <= 1'b1;
                    end
                    asm_q   <= {{(NCH - 1){1'b0}}, din};
                    state_q <= StRecv;
                end else if (state_q == StRecv) begin
                    if (cnt == '0) begin
                        sync_err <= 1'b1;
                        state_q  <= StHunt;
                    end else if (at_last) begin
                        dout       <= frame_word;
                        dout_valid <= 1'b1;
                    end else begin
                        for (int k = 0; k < NCH; k++) begin
                            if (cnt == SW'(k)) begin
                                asm_q[k] <= din;
                            end
                        end
                    end
                end
            end
        end
    end

    assign slot_idx = cnt;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Self-checking bench for tdm_demux_rx (NCH=8): table-driven frames plus hand-written
// sequences for early sync, lost sync and asynchronous reset. Completed frames are
// checked through a scoreboard queue popped whenever dout_valid is seen.
module tb_tdm_demux_rx;

    localparam int unsigned NCH = 8;
    localparam int unsigned SW  = 3;

    logic           clk;
    logic           rst;
    logic           din;
    logic           din_valid;
    logic           sync;
    logic [NCH-1:0] dout;
    logic           dout_valid;
    logic           sync_err;
    logic [SW-1:0]  slot_idx;

    int checks   = 0;
    int failures = 0;

    logic [NCH-1:0] exp_q[$];

    typedef struct {
        bit             rst_first;
        int             pre;
        int             gap;
        logic [NCH-1:0] bits;
        logic [NCH-1:0] exp;
    } vec_t;

    vec_t vecs[4];

    tdm_demux_rx #(
        .NCH (NCH),
        .SW  (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sync_err   (sync_err),
        .slot_idx   (slot_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every dout_valid must match the oldest expected frame.
    always @(posedge clk) begin
        #1;
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dout_valid", 32'(dout_valid), 32'd0);
            end else begin
                check("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
        if (dout_valid || sync_err) begin
            check("valid_err_exclusive", 32'(dout_valid && sync_err), 32'd0);
        end
    end

    // One beat; returns at posedge+1 with the beat's effect visible on the outputs.
    task automatic beat(input logic d, input logic s, input logic exp_err, input logic exp_vld);
        @(negedge clk);
        din_valid = 1'b1;
        din       = d;
        sync      = s;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sync      = 1'b0;
        check("beat_sync_err", 32'(sync_err), 32'(exp_err));
        check("beat_dout_valid", 32'(dout_valid), 32'(exp_vld));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [NCH-1:0] bits, input logic [NCH-1:0] exp,
                              input int gap);
        exp_q.push_back(exp);
        for (int k = 0; k < NCH; k++) begin
            beat(bits[k], k == 0, 1'b0, k == NCH - 1);
            if (gap > 0 && k != NCH - 1) idle(gap);
        end
        check("frame_dout", 32'(dout), 32'(exp));
        idle(1);
        check("valid_one_cycle", 32'(dout_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        sync      = 1'b0;

        vecs[0] = '{rst_first: 1'b0, pre: 0, gap: 0, bits: 8'h4D, exp: 8'h4D};
        vecs[1] = '{rst_first: 1'b0, pre: 0, gap: 3, bits: 8'h4D, exp: 8'h4D};
        vecs[2] = '{rst_first: 1'b1, pre: 5, gap: 0, bits: 8'hFF, exp: 8'hFF};
        vecs[3] = '{rst_first: 1'b0, pre: 0, gap: 1, bits: 8'hA6, exp: 8'hA6};

        #12;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        check("rst_slot_idx", 32'(slot_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven frames, with optional unsynchronised beats ignored in HUNT
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].rst_first) do_reset();
            for (int p = 0; p < vecs[i].pre; p++) begin
                beat(p[0], 1'b0, 1'b0, 1'b0);
                check("hunt_slot_idx", 32'(slot_idx), 32'd0);
            end
            send_frame(vecs[i].bits, vecs[i].exp, vecs[i].gap);
        end

        // Early sync: partial frame of 4 data beats then a new sync with din=0
        beat(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) beat(1'b1, 1'b0, 1'b0, 1'b0);
        check("early_prior_dout", 32'(dout), 32'hA6);
        exp_q.push_back(8'hFE);
        beat(1'b0, 1'b1, 1'b1, 1'b0);
        check("early_slot_idx", 32'(slot_idx), 32'd1);
        check("early_dout_held", 32'(dout), 32'hA6);
        for (int k = 1; k < NCH; k++) beat(1'b1, 1'b0, 1'b0, k == NCH - 1);
        check("early_dout", 32'(dout), 32'hFE);
        idle(1);

        // Lost sync: non-sync beat at slot 0 after a complete frame
        beat(1'b1, 1'b0, 1'b1, 1'b0);
        check("lost_slot_idx", 32'(slot_idx), 32'd0);
        beat(1'b1, 1'b0, 1'b0, 1'b0);
        check("lost_hunt_idx", 32'(slot_idx), 32'd0);
        check("lost_dout_held", 32'(dout), 32'hFE);
        send_frame(8'h3C, 8'h3C, 0);

        // Asynchronous reset mid-frame, off the clock edge
        beat(1'b1, 1'b1, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_dout", 32'(dout), 32'd0);
        check("arst_slot_idx", 32'(slot_idx), 32'd0);
        check("arst_dout_valid", 32'(dout_valid), 32'd0);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat(1'b1, 1'b0, 1'b0, 1'b0);
            check("arst_hunt_idx", 32'(slot_idx), 32'd0);
        end
        check("arst_dout_after", 32'(dout), 32'd0);
        send_frame(8'h81, 8'h81, 2);

        idle(3);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
